// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default abort timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 20000;
  localparam int unsigned BYTE_W          = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmit-engine bundle of the UART transmit arbiter.
// master: the arbiter side; slave: requesters plus transmit engine.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              busy;
  logic [IDW-1:0]    gnt_id;
  logic              err;

  modport master (
    input  req, req_data, tx_done,
    output ack, tx_start, tx_data, busy, gnt_id, err
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, tx_start, tx_data, busy, gnt_id, err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set request bit at or after rr_ptr, wrapping NREQ-1 -> 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  int unsigned cand;

  // Walk offsets 0..NREQ-1 from the pointer; the smallest offset with a request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!valid && req[IDW'(cand)]) begin
        valid = 1'b1;
        idx   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine among NREQ requesters.
// One byte per grant; IDLE -> START (tx_start pulse) -> BUSY (wait tx_done) -> IDLE.
// Optional abort timeout in BUSY is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              pick_valid;
  logic [IDW-1:0]    pick_idx;
  logic              timeout_hit;
  logic [BYTE_W-1:0] req_byte [NREQ];

  // Split the flat request data bus into per-requester bytes.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_byte[i] = bus.req_data[BYTE_W*i +: BYTE_W];
    end
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Abort when the final allowed BUSY cycle ends without tx_done; tx_done takes priority.
  assign timeout_hit = (state_q == BUSY) && !bus.tx_done && (cnt_q == CW'(TIMEOUT - 1));

  // BUSY cycle counter cleared on entry to START; err pulses for one cycle on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state_d == START) begin
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arbitration only happens in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = START;
      START:   state_d = BUSY;
      BUSY:    if (bus.tx_done || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next-cycle values for the registered outputs and grant bookkeeping.
  always_comb begin
    tx_start_d = 1'b0;
    busy_d     = 1'b0;
    ack_d      = '0;
    gnt_id_d   = gnt_id_q;
    tx_data_d  = tx_data_q;
    rr_ptr_d   = rr_ptr_q;

    tx_start_d = (state_d == START);
    busy_d     = (state_d != IDLE);

    if (state_q == IDLE && pick_valid) begin
      gnt_id_d  = pick_idx;
      tx_data_d = req_byte[pick_idx];
    end

    if (state_q == BUSY && (bus.tx_done || timeout_hit)) begin
      rr_ptr_d = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
      if (bus.tx_done) ack_d[gnt_id_q] = 1'b1;
    end
  end

  // Output and grant registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      gnt_id_q   <= '0;
      tx_data_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      gnt_id_q   <= gnt_id_d;
      tx_data_q  <= tx_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.ack      = ack_q;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4) against a round-robin reference model.
// Timeout scenarios are included when UART_ARB_TIMEOUT_EN is defined (TIMEOUT=50).
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 50;

  logic clk;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_ptr       = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first requester at or after the model pointer, wrapping.
  function automatic int exp_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // One granted transfer. tx_done is sampled at the end of BUSY cycle delay-1
  // (delay >= 3 when disturbing); withhold keeps tx_done low to force a timeout.
  task automatic xfer(input int delay, input bit withhold, input bit disturb);
    int         eg;
    logic [7:0] ed;
    int         n;
    eg = exp_pick(bus.req);
    ed = bus.req_data[8*eg +: 8];
    step();
    chk("start_pulse", bus.tx_start, 1);
    chk("gnt_id", bus.gnt_id, eg);
    chk("tx_data_grant", bus.tx_data, ed);
    chk("busy_start", bus.busy, 1);
    chk("ack_start", bus.ack, 0);
    n = withhold ? int'(TIMEOUT) : delay - 1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (i == 1) chk("start_one_cycle", bus.tx_start, 0);
      chk("tx_data_hold", bus.tx_data, ed);
      chk("busy_hold", bus.busy, 1);
      chk("ack_hold", bus.ack, 0);
      chk("err_hold", bus.err, 0);
      if (disturb && i == 2) begin
        bus.req_data = $urandom;
        bus.req      = '0;
      end
    end
    if (!withhold) begin
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      chk("ack_pulse", bus.ack, 32'(1) << eg);
      chk("busy_fall", bus.busy, 0);
      chk("err_none", bus.err, 0);
      chk("start_idle", bus.tx_start, 0);
    end else begin
      step();
      chk("err_pulse", bus.err, 1);
      chk("ack_none_timeout", bus.ack, 0);
      chk("busy_timeout", bus.busy, 0);
    end
    m_ptr = (eg + 1) % NREQ;
  endtask

  initial begin
    reset        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_done  = 1'b0;

    // Reset values.
    #3;
    chk("rst_ack", bus.ack, 0);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt", bus.gnt_id, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_err", bus.err, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single request from requester 2.
    bus.req      = 4'b0100;
    bus.req_data = {8'h11, 8'hA5, 8'h22, 8'h33};
    xfer(4, 1'b0, 1'b0);

    // tx_done while IDLE is ignored.
    bus.req     = '0;
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("idle_done_busy", bus.busy, 0);
    chk("idle_done_ack", bus.ack, 0);

    // Wrap: pointer at 3.
    bus.req = 4'b0011;
    xfer(3, 1'b0, 1'b0);
    bus.req = 4'b0100;
    xfer(3, 1'b0, 1'b0);
    bus.req = 4'b1001;
    xfer(3, 1'b0, 1'b0);

    // All requesting: rotation 0,1,2,3,0 with one IDLE cycle between transfers.
    bus.req      = 4'b1111;
    bus.req_data = $urandom;
    for (int t = 0; t < 5; t++) xfer(10, 1'b0, 1'b0);

    // Data change and request drop during BUSY.
    bus.req      = 4'b0010;
    bus.req_data = $urandom;
    xfer(6, 1'b0, 1'b1);

    // Reset in the middle of a transfer.
    bus.req = 4'b0100;
    step();
    chk("mid_start", bus.tx_start, 1);
    chk("mid_gnt", bus.gnt_id, 2);
    step();
    step();
    reset       = 1'b0;
    bus.tx_done = 1'b1;
    #1;
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_start", bus.tx_start, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_gnt", bus.gnt_id, 0);
    chk("mid_rst_data", bus.tx_data, 0);
    chk("mid_rst_err", bus.err, 0);
    step();
    chk("mid_rst_noack", bus.ack, 0);
    bus.tx_done = 1'b0;
    bus.req     = 4'b1000;
    m_ptr       = 0;
    reset       = 1'b1;
    xfer(5, 1'b0, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      bus.req      = 4'($urandom);
      bus.req_data = $urandom;
      if (bus.req == '0) begin
        step();
        chk("rand_idle_busy", bus.busy, 0);
        chk("rand_idle_start", bus.tx_start, 0);
      end else begin
        xfer(int'($urandom_range(3, 12)), 1'b0, $urandom_range(0, 3) == 0);
      end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Withheld tx_done aborts; the other pending requester is then served,
    // with tx_done arriving exactly at the final allowed count.
    bus.req      = 4'b0011;
    bus.req_data = $urandom;
    xfer(0, 1'b1, 1'b0);
    xfer(int'(TIMEOUT) + 1, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the UART transmitter; legal values 2..8.
REQ-002 Parameter TIMEOUT, default 20000, cycles allowed from tx_start to tx_done before abort; used only when UART_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester level request; bit i belongs to requester i.
REQ-006 req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 ack  output  NREQ  one-cycle pulse to the granted requester when its byte completes.
REQ-008 tx_start  output  1  one-cycle start pulse to the UART transmit engine.
REQ-009 tx_data  output  8  byte to the transmit engine, held stable from tx_start until completion.
REQ-010 tx_done  input  1  one-cycle pulse from the transmit engine when the stop bit has been sent.
REQ-011 busy  output  1  high whenever the arbiter is not in IDLE.
REQ-012 gnt_id  output  clog2(NREQ)  index of the current or most recent grant.
REQ-013 err  output  1  one-cycle pulse on timeout abort; tied 0 without UART_ARB_TIMEOUT_EN.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, START, BUSY.
REQ-015 In IDLE with req nonzero, the arbiter SHALL pick the first set bit at or after rr_ptr (searching upward with wrap from NREQ-1 to 0), latch its index into gnt_id and its byte into tx_data, and go to START.
REQ-016 In START, tx_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to BUSY; latency from req sampled in IDLE to tx_start high is 1 cycle.
REQ-017 In BUSY, on tx_done the arbiter SHALL pulse ack[gnt_id] for one cycle, set rr_ptr to (gnt_id+1) mod NREQ, and return to IDLE.
REQ-018 Arbitration SHALL occur only in IDLE; at most one byte per grant, so back-to-back transfers have exactly one IDLE cycle between them.
REQ-019 tx_done in IDLE or START SHALL be ignored.
REQ-020 A requester dropping req after grant SHALL NOT abort the transfer; ack is still issued.
REQ-021 Changes to req_data after grant SHALL NOT affect tx_data.
REQ-022 A requester still holding req in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-023 With all bits of req set continuously, grants SHALL rotate 0,1,...,NREQ-1,0 with no requester starved.

Reset
REQ-024 While reset is low: state IDLE, rr_ptr 0, gnt_id 0, tx_data 8'h00, tx_start 0, ack 0, busy 0, err 0.
REQ-025 Reset asserted mid-transfer SHALL abort immediately with no ack; after release arbitration restarts from requester 0.

Configuration
REQ-026 With UART_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to START and increment each BUSY cycle; reaching TIMEOUT without tx_done SHALL pulse err, issue no ack, advance rr_ptr as in REQ-017, and return to IDLE.
REQ-027 If tx_done arrives in the same cycle the count reaches TIMEOUT, tx_done SHALL win: ack is issued and err is not pulsed.
REQ-028 Without UART_ARB_TIMEOUT_EN, no counter SHALL be built, err SHALL be constant 0, and BUSY SHALL wait indefinitely for tx_done.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state encoding (IDLE, START, BUSY) and the default TIMEOUT constant.
REQ-030 The round-robin next-index search SHALL be a combinational sub-module rr_pick (inputs req and rr_ptr; outputs valid and idx).

Verification
REQ-031 Single request: req=4'b0100, byte 8'hA5 -> tx_start 1 cycle later with tx_data=A5, gnt_id=2; tx_done -> ack=4'b0100 next cycle and busy falls.
REQ-032 Simultaneous requests: req=4'b1111 held, tx_done returned 10 cycles after each tx_start -> grant order 0,1,2,3,0 with one IDLE cycle between transfers.
REQ-033 Wrap: rr_ptr=3, req=4'b0011 -> grant 0; with req=4'b1001 -> grant 3.
REQ-034 Data stability: change req_data and drop req while in BUSY -> tx_data unchanged and ack still issued.
REQ-035 Mid-transfer reset: reset low during BUSY -> all outputs at reset values in the same cycle, no ack; after release with req=4'b1000 -> grant 3.
REQ-036 Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT=50), tx_done withheld -> err pulse when the count reaches 50, no ack, next pending requester granted; tx_done at exactly that count -> ack and no err.
